// File: rtl/control_state_sequencer.sv
// Control-state register and Moore strobe decode for the microprogrammed MIPS control unit.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown dispatch codes in state 126.
module control_state_sequencer #(
    parameter int STATE_W     = 7,
    parameter int MOC_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic               MOC,
    input  logic               Cond,
    input  logic               Halt,
    output logic [STATE_W-1:0] State_Out,
    output logic               MAR_Ld,
    output logic               Mem_En,
    output logic               Mem_RW,
    output logic               IR_Ld,
    output logic               PC_Ld,
    output logic               RF_Ld,
    output logic               Bus_Err,
    output logic               Illegal_Op
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET      = STATE_W'(0),
        S_FETCH_ADDR = STATE_W'(1),
        S_FETCH_RD   = STATE_W'(2),
        S_IR_LOAD    = STATE_W'(3),
        S_DECODE     = STATE_W'(4),
        S_ADDU       = STATE_W'(6),
        S_ST_ADDR    = STATE_W'(7),
        S_ST_WR      = STATE_W'(8),
        S_BEQ_CMP    = STATE_W'(11),
        S_BR_TAKE    = STATE_W'(12),
        S_LD_ADDR    = STATE_W'(13),
        S_LD_RD      = STATE_W'(14),
        S_LD_WB      = STATE_W'(15),
        S_SUBU       = STATE_W'(17),
        S_ADDIU      = STATE_W'(18),
        S_SLTU       = STATE_W'(19),
        S_SLTIU      = STATE_W'(20),
        S_CLO        = STATE_W'(21),
        S_CLZ        = STATE_W'(22),
        S_ILLEGAL    = STATE_W'(126),
        S_BUS_ERR    = STATE_W'(127)
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              wd_expired;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    assign wd_expired = (wd_q == TO_W'(MOC_TIMEOUT - 1));

    // The watchdog defaults to zero, so it is already clear on entry to any memory-wait state.
    always_comb begin
        state_d = state_q;
        wd_d    = '0;
        case (state_q)
            S_RESET:      state_d = S_FETCH_ADDR;
            S_FETCH_ADDR: begin
                if (!Halt) begin
                    state_d = S_FETCH_RD;
                end
            end
            S_FETCH_RD: begin
                if (MOC) begin
                    state_d = S_IR_LOAD;
                end else if (wd_expired) begin
                    state_d = S_BUS_ERR;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            S_IR_LOAD:    state_d = S_DECODE;
            S_DECODE: begin
                case (State_Sel)
                    S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ,
                    S_ST_ADDR, S_BEQ_CMP, S_LD_ADDR: state_d = state_t'(State_Sel);
`ifdef ILLEGAL_TRAP_EN
                    default: state_d = S_ILLEGAL;
`else
                    // PC already advanced in IR_LOAD, so an unknown op behaves as a NOP.
                    default: state_d = S_FETCH_ADDR;
`endif
                endcase
            end
            S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ:
                          state_d = S_FETCH_ADDR;
            S_ST_ADDR:    state_d = S_ST_WR;
            S_ST_WR: begin
                if (MOC) begin
                    state_d = S_FETCH_ADDR;
                end else if (wd_expired) begin
                    state_d = S_BUS_ERR;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            S_BEQ_CMP:    state_d = Cond ? S_BR_TAKE : S_FETCH_ADDR;
            S_BR_TAKE:    state_d = S_FETCH_ADDR;
            S_LD_ADDR:    state_d = S_LD_RD;
            S_LD_RD: begin
                if (MOC) begin
                    state_d = S_LD_WB;
                end else if (wd_expired) begin
                    state_d = S_BUS_ERR;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            S_LD_WB:      state_d = S_FETCH_ADDR;
            S_BUS_ERR:    state_d = S_BUS_ERR;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL:    state_d = S_ILLEGAL;
`endif
            default:      state_d = S_FETCH_ADDR;
        endcase
    end

    always_comb begin
        MAR_Ld  = 1'b0;
        Mem_En  = 1'b0;
        Mem_RW  = 1'b0;
        IR_Ld   = 1'b0;
        PC_Ld   = 1'b0;
        RF_Ld   = 1'b0;
        Bus_Err = 1'b0;
        case (state_q)
            S_FETCH_ADDR, S_ST_ADDR, S_LD_ADDR: MAR_Ld = 1'b1;
            S_FETCH_RD, S_LD_RD: begin
                Mem_En = 1'b1;
                Mem_RW = 1'b1;
            end
            S_ST_WR:      Mem_En = 1'b1;
            S_IR_LOAD: begin
                IR_Ld = 1'b1;
                PC_Ld = 1'b1;
            end
            S_BR_TAKE:    PC_Ld = 1'b1;
            S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ, S_LD_WB:
                          RF_Ld = 1'b1;
            S_BUS_ERR:    Bus_Err = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign Illegal_Op = (state_q == S_ILLEGAL);
`else
    assign Illegal_Op = 1'b0;
`endif

    assign State_Out = state_q;

    a_rw_needs_en: assert property (@(posedge Clk) Mem_RW |-> Mem_En);

endmodule
